// File: rtl/cg_iteration_sequencer.sv
// Phase sequencer for one CG solve: preload, then iterate matvec/dot/alpha/update/dot/beta/update
// until convergence or the iteration limit. Optional macro CG_CYCLE_COUNT_EN adds a cycle_count output.
module cg_iteration_sequencer #(
  parameter int NO_OF_UNITS   = 8,
  parameter int ITER_WIDTH    = 11,
  parameter int FINISH_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [31:0]           total,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  a_load_done,
  input  logic                  matvec_done,
  input  logic                  vXv1_finish,
  input  logic                  div_done,
  input  logic                  converged,
  output logic                  memories_pre_preprocess,
  output logic                  start,
  output logic                  reset_vXv1,
  output logic                  read_again,
  output logic                  read_again_2,
  output logic                  finish_alu,
  output logic                  finish_all,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] iteration
`ifdef CG_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PRELOAD  = 4'd1;
  localparam logic [3:0] MATVEC   = 4'd2;
  localparam logic [3:0] DOT_RR   = 4'd3;
  localparam logic [3:0] ALPHA    = 4'd4;
  localparam logic [3:0] UPD_XR   = 4'd5;
  localparam logic [3:0] DOT_RNEW = 4'd6;
  localparam logic [3:0] BETA     = 4'd7;
  localparam logic [3:0] UPD_P    = 4'd8;
  localparam logic [3:0] ITER_END = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;

  localparam logic [31:0] FINISH_LAST = 32'(FINISH_CYCLES - 1);

  logic [3:0]            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           n_words_q, n_words_d;
  logic [ITER_WIDTH-1:0] max_iter_q, max_iter_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [31:0]           go_words;
  logic                  limit_hit;

  logic mpp_q, start_q, rv_q, ra_q, ra2_q, fa_q, fall_q, busy_q;

  assign go_words  = total / 32'(NO_OF_UNITS);
  // Decision is taken on the value before this iteration's increment, widened so all-ones cannot wrap.
  assign limit_hit = ({1'b0, iter_q} + {{ITER_WIDTH{1'b0}}, 1'b1}) >= {1'b0, max_iter_q};

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_words_d  = n_words_q;
    max_iter_d = max_iter_q;
    iter_d     = iter_q;
    case (state_q)
      IDLE: if (go) begin
        n_words_d  = go_words;
        max_iter_d = (max_iter == '0) ? {{(ITER_WIDTH-1){1'b0}}, 1'b1} : max_iter;
        iter_d     = '0;
        cnt_d      = '0;
        state_d    = (go_words == 32'd0) ? DONE : PRELOAD;
      end
      PRELOAD:  if (a_load_done) state_d = MATVEC;
      MATVEC:   if (matvec_done) state_d = DOT_RR;
      DOT_RR:   if (vXv1_finish) state_d = ALPHA;
      ALPHA: if (div_done) begin
        state_d = UPD_XR;
        cnt_d   = '0;
      end
      UPD_XR: if (cnt_q == n_words_q - 32'd1) begin
        state_d = DOT_RNEW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      DOT_RNEW: if (vXv1_finish) state_d = BETA;
      BETA: if (div_done) begin
        state_d = UPD_P;
        cnt_d   = '0;
      end
      UPD_P: if (cnt_q == n_words_q - 32'd1) begin
        state_d = ITER_END;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      ITER_END: if (cnt_q == FINISH_LAST) begin
        cnt_d = '0;
        if (iter_q != {ITER_WIDTH{1'b1}}) iter_d = iter_q + {{(ITER_WIDTH-1){1'b0}}, 1'b1};
        state_d = (converged || limit_hit) ? DONE : MATVEC;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_words_q  <= '0;
      max_iter_q <= '0;
      iter_q     <= '0;
      mpp_q      <= 1'b0;
      start_q    <= 1'b0;
      rv_q       <= 1'b1;
      ra_q       <= 1'b0;
      ra2_q      <= 1'b0;
      fa_q       <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_words_q  <= n_words_d;
      max_iter_q <= max_iter_d;
      iter_q     <= iter_d;
      // Strobes are decoded from the next state so the registered outputs line up with state_q.
      mpp_q      <= (state_d == PRELOAD);
      start_q    <= (state_d == MATVEC);
      rv_q       <= !((state_d == DOT_RR) || (state_d == DOT_RNEW));
      ra_q       <= (state_d == UPD_XR);
      ra2_q      <= (state_d == UPD_P);
      fa_q       <= (state_d == ITER_END);
      fall_q     <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign memories_pre_preprocess = mpp_q;
  assign start                   = start_q;
  assign reset_vXv1              = rv_q;
  assign read_again              = ra_q;
  assign read_again_2            = ra2_q;
  assign finish_alu              = fa_q;
  assign finish_all              = fall_q;
  assign busy                    = busy_q;
  assign iteration               = iter_q;

`ifdef CG_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (go) cyc_d = '0;
    end else if (cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer: an output-driven responder answers done strobes
// two cycles after each phase entry; a monitor counts strobe cycles for per-scenario checks.
module tb_cg_iteration_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [31:0] total = 32'd0;
  logic [10:0] max_iter = 11'd0;
  logic        converged = 1'b0;
  logic [3:0]  auto_s = 4'b0;
  logic [3:0]  man_s = 4'b0;
  logic [3:0]  strb;
  logic        auto_en = 1'b0;

  logic        mpp, start, rv, ra, ra2, fa, fall, busy;
  logic [10:0] iteration;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail = 0;

  assign strb = auto_s | man_s;

  always #5 clk = ~clk;

  cg_iteration_sequencer #(.NO_OF_UNITS(8), .ITER_WIDTH(11), .FINISH_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .go(go), .total(total), .max_iter(max_iter),
    .a_load_done(strb[0]), .matvec_done(strb[1]), .vXv1_finish(strb[2]), .div_done(strb[3]),
    .converged(converged),
    .memories_pre_preprocess(mpp), .start(start), .reset_vXv1(rv), .read_again(ra),
    .read_again_2(ra2), .finish_alu(fa), .finish_all(fall), .busy(busy), .iteration(iteration)
`ifdef CG_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

`ifndef CG_CYCLE_COUNT_EN
  assign cycle_count = 32'd0;
`endif

  // Responder: one strobe, raised on the second observed cycle of a phase, for one cycle.
  logic [7:0] sig_prev = 8'h00;
  int age = 0;
  always @(negedge clk) begin
    logic [7:0] sig;
    sig = {mpp, start, rv, ra, ra2, fa, fall, busy};
    if (sig != sig_prev) age = 0;
    else age = age + 1;
    sig_prev = sig;
    auto_s = 4'b0;
    if (auto_en && !reset && age == 1) begin
      if (mpp) auto_s[0] = 1'b1;
      else if (start) auto_s[1] = 1'b1;
      else if (!rv) auto_s[2] = 1'b1;
      else if (busy && !ra && !ra2 && !fa && !fall) auto_s[3] = 1'b1;
    end
  end

  // Monitor: free-running counters; scenarios compare differences against snapshots.
  int n_ra = 0, n_ra2 = 0, n_fa = 0, n_fall = 0, n_busy = 0, n_dot = 0;
  int n_pre_rise = 0, n_start_rise = 0, n_ra_runs = 0, n_ra2_runs = 0;
  logic p_mpp = 1'b0, p_start = 1'b0, p_ra = 1'b0, p_ra2 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ra) n_ra++;
    if (ra2) n_ra2++;
    if (fa) n_fa++;
    if (fall) n_fall++;
    if (busy) n_busy++;
    if (!rv) n_dot++;
    if (mpp && !p_mpp) n_pre_rise++;
    if (start && !p_start) n_start_rise++;
    if (ra && !p_ra) n_ra_runs++;
    if (ra2 && !p_ra2) n_ra2_runs++;
    p_mpp = mpp; p_start = start; p_ra = ra; p_ra2 = ra2;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; go = 1'b0; man_s = 4'b0; auto_en = 1'b0; converged = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_solve(input logic [31:0] tot, input logic [10:0] mi);
    @(negedge clk);
    total = tot; max_iter = mi; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    man_s = v;
    @(negedge clk);
    man_s = 4'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fall) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: finish_all not seen within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({mpp, start, rv, ra, ra2, fa, fall, busy} !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00100000", {mpp, start, rv, ra, ra2, fa, fall, busy});
    end
    n_checks++;
    if (iteration !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_iteration: got %0d expected 0", iteration);
    end
  endtask

  task automatic test_reset_mid_update();
    int b_ra;
    logic ok;
    do_reset();
    auto_en = 1'b1;
    b_ra = n_ra;
    ok = 1'b0;
    start_solve(32'd256, 11'd3);
    for (int i = 0; i < 500; i++) begin
      if (n_ra - b_ra == 10) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!(ok && ra)) begin
      n_fail++;
      $display("FAIL midreset_reach: ok=%0d read_again=%0d expected 1 1", ok, ra);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mpp, start, rv, ra, ra2, fa, fall, busy} !== 8'b0010_0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected 00100000", {mpp, start, rv, ra, ra2, fa, fall, busy});
    end
    n_checks++;
    if (iteration !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_iteration: got %0d expected 0", iteration);
    end
    reset = 1'b0;
    auto_en = 1'b0;
  endtask

  task automatic test_iterations();
    int b_ra, b_ra2, b_fa, b_fall, b_pre, b_start, b_busy, b_rr, b_rr2;
    do_reset();
    auto_en = 1'b1;
    b_ra = n_ra; b_ra2 = n_ra2; b_fa = n_fa; b_fall = n_fall; b_pre = n_pre_rise;
    b_start = n_start_rise; b_busy = n_busy; b_rr = n_ra_runs; b_rr2 = n_ra2_runs;
    start_solve(32'd256, 11'd3);
    // Inputs changed while busy must be ignored.
    total = 32'd8; max_iter = 11'd1;
    wait_done(2000, "iter");
    n_checks++;
    if (n_ra - b_ra !== 96 || n_ra_runs - b_rr !== 3) begin
      n_fail++;
      $display("FAIL iter_read_again: cycles=%0d runs=%0d expected 96 3", n_ra - b_ra, n_ra_runs - b_rr);
    end
    n_checks++;
    if (n_ra2 - b_ra2 !== 96 || n_ra2_runs - b_rr2 !== 3) begin
      n_fail++;
      $display("FAIL iter_read_again_2: cycles=%0d runs=%0d expected 96 3", n_ra2 - b_ra2, n_ra2_runs - b_rr2);
    end
    n_checks++;
    if (n_fa - b_fa !== 15) begin
      n_fail++;
      $display("FAIL iter_finish_alu: got %0d expected 15", n_fa - b_fa);
    end
    n_checks++;
    if (n_fall - b_fall !== 1 || n_pre_rise - b_pre !== 1 || n_start_rise - b_start !== 3) begin
      n_fail++;
      $display("FAIL iter_phases: finish_all=%0d preload=%0d matvec=%0d expected 1 1 3",
               n_fall - b_fall, n_pre_rise - b_pre, n_start_rise - b_start);
    end
    n_checks++;
    if (iteration !== 11'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL iter_count: iteration=%0d busy=%0d expected 3 0", iteration, busy);
    end
    n_checks++;
    if (n_busy - b_busy !== 240) begin
      n_fail++;
      $display("FAIL iter_busy_cycles: got %0d expected 240", n_busy - b_busy);
    end
`ifdef CG_CYCLE_COUNT_EN
    n_checks++;
    if (cycle_count !== 32'd240) begin
      n_fail++;
      $display("FAIL cycle_count: got %0d expected 240", cycle_count);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (cycle_count !== 32'd240) begin
      n_fail++;
      $display("FAIL cycle_count_hold: got %0d expected 240", cycle_count);
    end
`endif
  endtask

  task automatic test_converged();
    int b_fa, b_pre, b_start, b_ra;
    do_reset();
    auto_en = 1'b1;
    converged = 1'b1;
    b_fa = n_fa; b_pre = n_pre_rise; b_start = n_start_rise;
    start_solve(32'd256, 11'd10);
    wait_done(1000, "conv");
    n_checks++;
    if (iteration !== 11'd1 || n_fa - b_fa !== 5) begin
      n_fail++;
      $display("FAIL conv_iteration: iteration=%0d finish_alu=%0d expected 1 5", iteration, n_fa - b_fa);
    end
    n_checks++;
    if (n_pre_rise - b_pre !== 1 || n_start_rise - b_start !== 1) begin
      n_fail++;
      $display("FAIL conv_phases: preload=%0d matvec=%0d expected 1 1", n_pre_rise - b_pre, n_start_rise - b_start);
    end
    // max_iter of zero behaves as a limit of one; n_words=1 here.
    converged = 1'b0;
    b_ra = n_ra;
    start_solve(32'd8, 11'd0);
    wait_done(1000, "maxzero");
    n_checks++;
    if (iteration !== 11'd1 || n_ra - b_ra !== 1) begin
      n_fail++;
      $display("FAIL maxzero: iteration=%0d read_again=%0d expected 1 1", iteration, n_ra - b_ra);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_zero_words();
    int b_other;
    do_reset();
    b_other = n_ra + n_ra2 + n_fa + n_pre_rise + n_start_rise + n_dot;
    start_solve(32'd7, 11'd3);
    n_checks++;
    if (fall !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: finish_all=%0d busy=%0d expected 1 1", fall, busy);
    end
    @(negedge clk);
    n_checks++;
    if (fall !== 1'b0 || busy !== 1'b0 || iteration !== 11'd0) begin
      n_fail++;
      $display("FAIL zero_idle: finish_all=%0d busy=%0d iteration=%0d expected 0 0 0", fall, busy, iteration);
    end
    n_checks++;
    if (n_ra + n_ra2 + n_fa + n_pre_rise + n_start_rise + n_dot - b_other !== 0) begin
      n_fail++;
      $display("FAIL zero_strobes: got %0d other strobe cycles expected 0",
               n_ra + n_ra2 + n_fa + n_pre_rise + n_start_rise + n_dot - b_other);
    end
  endtask

  task automatic test_spurious();
    int n;
    do_reset();
    start_solve(32'd256, 11'd3);
    n_checks++;
    if (mpp !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_preload: got %0d expected 1", mpp);
    end
    pulse(4'b0001);
    pulse(4'b1100);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_checks++;
    if (start !== 1'b1 || mpp !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_matvec: start=%0d preload=%0d busy=%0d expected 1 0 1", start, mpp, busy);
    end
    pulse(4'b0010);
    n_checks++;
    if (rv !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_dot_rr: reset_vXv1=%0d expected 0", rv);
    end
    pulse(4'b0100);
    pulse(4'b1000);
    n = 0;
    while (ra && n < 100) begin
      n++;
      man_s = (n == 3 || n == 10) ? 4'b1100 : 4'b0000;
      @(negedge clk);
    end
    man_s = 4'b0;
    n_checks++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL spur_upd_xr_len: got %0d expected 32", n);
    end
    @(negedge clk);
    n_checks++;
    if (rv !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_no_early_latch: reset_vXv1=%0d busy=%0d expected 0 1", rv, busy);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_reset_mid_update();
    test_iterations();
    test_converged();
    test_zero_words();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
